// File: rtl/fetch_decode.sv
// Instruction-side producer: owns the PC, fetches from a sync-read ROM, decodes and
// issues one control bundle at a time with a valid/ready handshake.
module fetch_decode #(
  parameter int unsigned           DATA_WIDTH    = 32,
  parameter int unsigned           ADDRESS_WIDTH = 5,
  parameter int unsigned           ALUctrl_WIDTH = 3,
  parameter logic [DATA_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [DATA_WIDTH-1:0]    imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic                     ctrl_valid,
  input  logic                     ctrl_ready,
  output logic [DATA_WIDTH-1:0]    ImmOp,
  output logic                     RegWrite,
  output logic [ALUctrl_WIDTH-1:0] ALUctrl,
  output logic                     ALUsrc,
  output logic [ADDRESS_WIDTH-1:0] rs1,
  output logic [ADDRESS_WIDTH-1:0] rs2,
  output logic [ADDRESS_WIDTH-1:0] rd,
  output logic                     MemWrite,
  output logic                     ResultSrc,
  input  logic                     EQ,
  output logic [DATA_WIDTH-1:0]    pc,
  output logic                     illegal
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [ALUctrl_WIDTH-1:0] ALU_ADD = ALUctrl_WIDTH'(3'b000);
  localparam logic [ALUctrl_WIDTH-1:0] ALU_SUB = ALUctrl_WIDTH'(3'b001);
  localparam logic [ALUctrl_WIDTH-1:0] ALU_AND = ALUctrl_WIDTH'(3'b010);
  localparam logic [ALUctrl_WIDTH-1:0] ALU_OR  = ALUctrl_WIDTH'(3'b011);
  localparam logic [ALUctrl_WIDTH-1:0] ALU_SLT = ALUctrl_WIDTH'(3'b101);

  typedef enum logic [1:0] {FETCH, DECODE, ISSUE} state_e;

  state_e state_q, state_d;
  logic   hs;

  logic [DATA_WIDTH-1:0]    pc_q, pc_d;
  logic [DATA_WIDTH-1:0]    imm_q, imm_d;
  logic [ALUctrl_WIDTH-1:0] alu_q, alu_d;
  logic [ADDRESS_WIDTH-1:0] rs1_q, rs1_d, rs2_q, rd_q;
  logic alusrc_q, alusrc_d, resultsrc_q, resultsrc_d;
  logic regwrite_q, regwrite_d, memwrite_q, memwrite_d;
  logic branch_q, branch_d, bne_q, bne_d, illegal_q, illegal_d;

  logic [31:0] instr, imm_i, imm_s, imm_b, imm_u, imm_sel;
  logic [6:0]  funct7;
  logic [2:0]  funct3;

  assign instr  = imem_rdata[31:0];
  assign funct7 = instr[31:25];
  assign funct3 = instr[14:12];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_d  = DATA_WIDTH'($signed(imm_sel));

  // Instruction decode; anything unrecognised collapses to a NOP flagged illegal
  always_comb begin
    imm_sel     = '0;
    alu_d       = ALU_ADD;
    alusrc_d    = 1'b0;
    resultsrc_d = 1'b0;
    regwrite_d  = 1'b0;
    memwrite_d  = 1'b0;
    branch_d    = 1'b0;
    bne_d       = funct3[0];
    illegal_d   = 1'b0;
    rs1_d       = ADDRESS_WIDTH'(instr[19:15]);
    case (instr[6:0])
      OP_R: begin
        regwrite_d = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  alu_d = ALU_ADD;
            3'b111:  alu_d = ALU_AND;
            3'b110:  alu_d = ALU_OR;
            3'b010:  alu_d = ALU_SLT;
            default: illegal_d = 1'b1;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          alu_d = ALU_SUB;
        end else begin
          illegal_d = 1'b1;
        end
      end
      OP_ADDI: begin
        imm_sel    = imm_i;
        alusrc_d   = 1'b1;
        regwrite_d = 1'b1;
        illegal_d  = (funct3 != 3'b000);
      end
      OP_LW: begin
        imm_sel     = imm_i;
        alusrc_d    = 1'b1;
        regwrite_d  = 1'b1;
        resultsrc_d = 1'b1;
        illegal_d   = (funct3 != 3'b010);
      end
      OP_SW: begin
        imm_sel    = imm_s;
        alusrc_d   = 1'b1;
        memwrite_d = 1'b1;
        illegal_d  = (funct3 != 3'b010);
      end
      OP_BR: begin
        imm_sel   = imm_b;
        alu_d     = ALU_SUB;
        branch_d  = 1'b1;
        illegal_d = (funct3[2:1] != 2'b00);
      end
      OP_LUI: begin
        imm_sel    = imm_u;
        rs1_d      = '0;
        alusrc_d   = 1'b1;
        regwrite_d = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase
    if (illegal_d) begin
      imm_sel     = '0;
      alu_d       = ALU_ADD;
      alusrc_d    = 1'b0;
      resultsrc_d = 1'b0;
      regwrite_d  = 1'b0;
      memwrite_d  = 1'b0;
      branch_d    = 1'b0;
    end
  end

  // Sequencing and handshake detection
  always_comb begin
    state_d    = state_q;
    ctrl_valid = 1'b0;
    hs         = 1'b0;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: state_d = ISSUE;
      ISSUE: begin
        ctrl_valid = 1'b1;
        if (ctrl_ready) begin
          hs      = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    pc_d = pc_q + DATA_WIDTH'(4);
    if (branch_q && (bne_q ? !EQ : EQ)) pc_d = pc_q + imm_q;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst)     pc_q <= RESET_PC;
    else if (hs) pc_q <= pc_d;
  end

  // Bundle registers load once per instruction and stay frozen through ISSUE
  always_ff @(posedge clk) begin
    if (rst) begin
      imm_q       <= '0;
      alu_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alusrc_q    <= 1'b0;
      resultsrc_q <= 1'b0;
      regwrite_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      branch_q    <= 1'b0;
      bne_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (state_q == DECODE) begin
      imm_q       <= imm_d;
      alu_q       <= alu_d;
      rs1_q       <= rs1_d;
      rs2_q       <= ADDRESS_WIDTH'(instr[24:20]);
      rd_q        <= ADDRESS_WIDTH'(instr[11:7]);
      alusrc_q    <= alusrc_d;
      resultsrc_q <= resultsrc_d;
      regwrite_q  <= regwrite_d;
      memwrite_q  <= memwrite_d;
      branch_q    <= branch_d;
      bne_q       <= bne_d;
      illegal_q   <= illegal_d;
    end
  end

  // Write enables only fire in a handshake cycle that is not being reset
  assign RegWrite  = regwrite_q && hs && !rst;
  assign MemWrite  = memwrite_q && hs && !rst;
  assign illegal   = illegal_q && hs && !rst;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ImmOp     = imm_q;
  assign ALUctrl   = alu_q;
  assign ALUsrc    = alusrc_q;
  assign ResultSrc = resultsrc_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign rd        = rd_q;

endmodule

// File: doc/fetch_decode.md
Name: fetch_decode

Overview:
- Instruction-side producer for the reduced RISC-V datapath: owns the PC, fetches from a synchronous-read instruction ROM, decodes, and drives the control bundle the datapath top consumes: ImmOp, RegWrite, ALUctrl, ALUsrc, rs1, rs2, rd, MemWrite, ResultSrc.
- Multi-cycle and non-pipelined; one instruction in flight.
- Consumes EQ back from the ALU to resolve branches.

Parameters:
- DATA_WIDTH, 32, width of instruction, PC and ImmOp.
- ADDRESS_WIDTH, 5, register-index width.
- ALUctrl_WIDTH, 3, ALU control width.
- RESET_PC, 32'h0, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- imem_addr  output  DATA_WIDTH  instruction ROM address; ROM returns imem_rdata one cycle later.
- imem_rdata  input  DATA_WIDTH  instruction word.
- ctrl_valid  output  1  control bundle valid.
- ctrl_ready  input  1  datapath accepts bundle this cycle.
- ImmOp  output  DATA_WIDTH  sign-extended immediate.
- RegWrite  output  1  register-file write enable; qualified by handshake.
- ALUctrl  output  ALUctrl_WIDTH  encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT.
- ALUsrc  output  1  1 selects ImmOp as ALU operand 2.
- rs1, rs2, rd  output  ADDRESS_WIDTH  register indices.
- MemWrite  output  1  data-memory write enable; qualified by handshake.
- ResultSrc  output  1  1 selects memory read data for writeback.
- EQ  input  1  ALU zero flag, combinational from the datapath.
- pc  output  DATA_WIDTH  PC of the current instruction.
- illegal  output  1  one-cycle pulse on an undecodable instruction.

Behaviour:
- FSM states: FETCH -> DECODE -> ISSUE -> FETCH.
  - FETCH: imem_addr = pc.
  - DECODE: latch imem_rdata and register all decoded fields.
  - ISSUE: ctrl_valid = 1 until ctrl_valid && ctrl_ready (the handshake cycle).
- Minimum 3 cycles per instruction. Each extra ctrl_ready-low cycle in ISSUE adds one cycle.
- Reset (rst=1 at an edge): state = FETCH, pc = RESET_PC, ctrl_valid = 0, illegal = 0. All bundle outputs are 0.
- Reset in any state, including mid-ISSUE, aborts the instruction. No write enable is asserted in the cycle after.
- Stability: ImmOp, ALUctrl, ALUsrc, rs1, rs2, rd, ResultSrc are registered and held constant for all of ISSUE.
- RegWrite = dec_regwrite && ctrl_valid && ctrl_ready. MemWrite is qualified the same way. Both are 0 in every other cycle.
- Decoding, by opcode:
  - 0110011 R-type, with funct3/funct7:
    - add f3=000,f7=0 -> ADD
    - sub f3=000,f7=0100000 -> SUB
    - and 111 -> AND
    - or 110 -> OR
    - slt 010 -> SLT
    - All R-type: ALUsrc=0, RegWrite=1.
  - 0010011 addi (f3=000): I-imm, ALUsrc=1, ADD, RegWrite=1.
  - 0000011 lw (f3=010): I-imm, ALUsrc=1, ADD, RegWrite=1, ResultSrc=1.
  - 0100011 sw (f3=010): S-imm, ALUsrc=1, ADD, MemWrite=1, RegWrite=0.
  - 1100011 beq (000) / bne (001): B-imm, ALUsrc=0, SUB, no writes.
  - 0110111 lui: ImmOp = {instr[31:12],12'b0}, rs1 forced to 0, ALUsrc=1, ADD, RegWrite=1.
- Immediates are sign-extended from instr[31]. The B-immediate has bit 0 = 0.
- rs1/rs2/rd are always taken from instr[19:15], [24:20], [11:7], except the lui rs1 override.
- PC update, applied in the handshake cycle only:
  - beq taken when EQ=1; bne taken when EQ=0. EQ is sampled in the handshake cycle.
  - Taken: pc <= pc + B-imm.
  - Otherwise: pc <= pc + 4.
  - Addition is modulo 2^32; 0xFFFFFFFC + 4 wraps to 0.
- Illegal (unlisted opcode or funct combination):
  - Decoded as NOP: all enables 0, ALUctrl=000.
  - Still handshaked in ISSUE.
  - illegal pulses for exactly the handshake cycle.
  - pc <= pc + 4.
- The PC never changes outside the handshake cycle. ctrl_ready is ignored outside ISSUE.

Test Plan:
- Reset with RESET_PC=0, then instr 0x00500093 (addi x1,x0,5), ctrl_ready=1 -> in ISSUE: ImmOp=5, rs1=0, rd=1, ALUsrc=1, ALUctrl=000, RegWrite=1 for one cycle; next imem_addr=0x4.
- At pc=0x8, instr 0xFE009CE3 (bne x1,x0,-8), EQ=0 -> ALUctrl=001, ALUsrc=0, no writes, next imem_addr=0x0. Repeat with EQ=1 -> next imem_addr=0xC.
- instr 0x0020A223 (sw x2,4(x1)) with ctrl_ready low for 3 ISSUE cycles -> ctrl_valid high and fields stable (ImmOp=4, rs1=1, rs2=2) for all 4 ISSUE cycles; MemWrite=1 only in the 4th cycle; RegWrite stays 0.
- instr 0xFFFFFFFF -> illegal=1 for one cycle, RegWrite=MemWrite=0, pc advances by 4.
- rst=1 during ISSUE of an addi with ctrl_ready=1 -> no RegWrite pulse; next cycle ctrl_valid=0, imem_addr=RESET_PC.
- pc=0xFFFFFFFC executing addi -> next pc=0x0.
